// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simon_pkg
// Description : Shared state encoding and width/one-hot helpers for the
//               Simon sequence engine.
// Revision    : 1.0 - initial release
// ============================================================================
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADD      = 3'd1,
        SHOW_ON  = 3'd2,
        SHOW_OFF = 3'd3,
        INPUT    = 3'd4,
        WIN      = 3'd5,
        LOSE     = 3'd6
    } state_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int lvl_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int addr_w(input int max_len);
        return (max_len <= 2) ? 1 : $clog2(max_len);
    endfunction

    // Colour index to LED pattern; indices outside 0..n-1 give an all-dark pattern.
    function automatic logic [7:0] onehot(input logic [2:0] idx, input int n);
        logic [7:0] v;
        v = '0;
        if (int'(idx) < n) v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/simon_seq_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : simon_seq_engine_if
// Description : Game-side signal bundle between the engine and its
//               tick/random sources and the LED/display logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface simon_seq_engine_if
    import simon_pkg::*;
#(
    parameter int N_BTN   = 4,
    parameter int MAX_LEN = 16
);
    localparam int c_IDX_W = idx_w(N_BTN);
    localparam int c_LVL_W = lvl_w(MAX_LEN);

    logic               tick;
    logic               start;
    logic [N_BTN-1:0]   btn;
    logic [c_IDX_W-1:0] rnd;
    logic [N_BTN-1:0]   led;
    logic [c_LVL_W-1:0] level;
    logic               busy;
    logic               win;
    logic               lose;

    modport master (
        output tick, start, btn, rnd,
        input  led, level, busy, win, lose
    );

    modport slave (
        input  tick, start, btn, rnd,
        output led, level, busy, win, lose
    );
endinterface
`default_nettype wire

// File: rtl/simon_seq_ram.sv
`default_nettype none
// ============================================================================
// Module      : simon_seq_ram
// Description : Colour sequence store; synchronous write, combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
module simon_seq_ram #(
    parameter int MAX_LEN = 16,
    parameter int IDX_W   = 2,
    parameter int AW      = 4
) (
    input  wire logic             clk,
    input  wire logic             w_en,
    input  wire logic [AW-1:0]    w_addr,
    input  wire logic [IDX_W-1:0] w_data,
    input  wire logic [AW-1:0]    r_addr,
    output      logic [IDX_W-1:0] r_data
);
    logic [IDX_W-1:0] r_mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (w_en) r_mem[w_addr] <= w_data;
    end

    // Playback look-ahead can address one past the last entry; return a benign value.
    assign r_data = (int'(r_addr) < MAX_LEN) ? r_mem[r_addr] : '0;
endmodule
`default_nettype wire

// File: rtl/simon_seq_engine.sv
`default_nettype none
// ============================================================================
// Module      : simon_seq_engine
// Description : Simon Says engine: grows, plays back and checks a colour
//               sequence. Define SIMON_SPEEDUP_EN to shorten LED on-time as
//               the sequence grows.
// Revision    : 1.0 - initial release
// ============================================================================
module simon_seq_engine
    import simon_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int MAX_LEN       = 16,
    parameter int SHOW_TICKS    = 4,
    parameter int GAP_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 32
) (
    input wire logic          clk,
    input wire logic          rst,
    simon_seq_engine_if.slave bus
);
    localparam int c_IDX_W  = idx_w(N_BTN);
    localparam int c_LVL_W  = lvl_w(MAX_LEN);
    localparam int c_AW     = addr_w(MAX_LEN);
    localparam int c_CNT_MX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int c_CNT_W  = $clog2(c_CNT_MX + 1);
    localparam int c_TMR_W  = $clog2(TIMEOUT_TICKS + 1);

    state_t             r_state, w_state_nxt;
    logic [c_AW-1:0]    r_idx, w_idx_nxt, w_raddr, w_waddr;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt, w_on_ticks;
    logic [c_TMR_W-1:0] r_timer, w_timer_nxt;
    logic [c_LVL_W-1:0] r_level, w_level_nxt;
    logic [N_BTN-1:0]   r_btn_prev, r_led, w_led_nxt, w_expect, w_show_oh;
    logic [c_IDX_W-1:0] w_rnd_mod, w_rdata, w_show_data;
    logic               r_busy, r_win, r_lose;
    logic               w_we, w_press, w_last;
    int                 w_trim;

    assign w_rnd_mod = c_IDX_W'(32'(bus.rnd) % $unsigned(N_BTN));
    assign w_press   = (|bus.btn) && !(|r_btn_prev);
    assign w_last    = (c_LVL_W'(r_idx) == r_level - c_LVL_W'(1));
    assign w_we      = (r_state == ADD);
    assign w_waddr   = r_level[c_AW-1:0];

    // Read port looks ahead to the entry shown next; in INPUT it serves the compare.
    always_comb begin
        case (r_state)
            ADD:      w_raddr = '0;
            SHOW_OFF: w_raddr = r_idx + c_AW'(1);
            default:  w_raddr = r_idx;
        endcase
    end

    simon_seq_ram #(
        .MAX_LEN (MAX_LEN),
        .IDX_W   (c_IDX_W),
        .AW      (c_AW)
    ) u_ram (
        .clk    (clk),
        .w_en   (w_we),
        .w_addr (w_waddr),
        .w_data (w_rnd_mod),
        .r_addr (w_raddr),
        .r_data (w_rdata)
    );

    assign w_show_data = (w_we && (w_waddr == w_raddr)) ? w_rnd_mod : w_rdata;
    assign w_show_oh   = N_BTN'(onehot(3'(w_show_data), N_BTN));
    assign w_expect    = N_BTN'(onehot(3'(w_rdata), N_BTN));

    always_comb begin
        w_trim = 0;
`ifdef SIMON_SPEEDUP_EN
        if (r_level != '0) w_trim = int'(r_level) - 1;
        if (w_trim > SHOW_TICKS / 2) w_trim = SHOW_TICKS / 2;
`endif
        w_on_ticks = c_CNT_W'(SHOW_TICKS - w_trim);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_timer_nxt = r_timer;
        w_level_nxt = r_level;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_level_nxt = '0;
                    w_state_nxt = ADD;
                end
            end
            ADD: begin
                w_level_nxt = r_level + c_LVL_W'(1);
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = SHOW_ON;
            end
            SHOW_ON: begin
                if (bus.tick) begin
                    if (r_cnt == w_on_ticks - c_CNT_W'(1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = SHOW_OFF;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
            end
            SHOW_OFF: begin
                if (bus.tick) begin
                    if (r_cnt == c_CNT_W'(GAP_TICKS - 1)) begin
                        w_cnt_nxt = '0;
                        if (w_last) begin
                            w_idx_nxt   = '0;
                            w_timer_nxt = '0;
                            w_state_nxt = INPUT;
                        end else begin
                            w_idx_nxt   = r_idx + c_AW'(1);
                            w_state_nxt = SHOW_ON;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
            end
            INPUT: begin
                // A press takes priority over an expiring timer.
                if (w_press) begin
                    if (bus.btn != w_expect) begin
                        w_state_nxt = LOSE;
                    end else if (!w_last) begin
                        w_idx_nxt   = r_idx + c_AW'(1);
                        w_timer_nxt = '0;
                    end else if (r_level == c_LVL_W'(MAX_LEN)) begin
                        w_state_nxt = WIN;
                    end else begin
                        w_state_nxt = ADD;
                    end
                end else if (r_timer == c_TMR_W'(TIMEOUT_TICKS)) begin
                    w_state_nxt = LOSE;
                end else if (bus.tick) begin
                    w_timer_nxt = r_timer + c_TMR_W'(1);
                end
            end
            WIN, LOSE: begin
                if (bus.start) begin
                    w_level_nxt = '0;
                    w_state_nxt = ADD;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_led_nxt = '0;
        case (w_state_nxt)
            SHOW_ON: w_led_nxt = (r_state == SHOW_ON) ? r_led : w_show_oh;
            INPUT:   w_led_nxt = bus.btn;
            default: w_led_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_timer    <= '0;
            r_level    <= '0;
            r_btn_prev <= '0;
            r_led      <= '0;
            r_busy     <= 1'b0;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_timer    <= w_timer_nxt;
            r_level    <= w_level_nxt;
            r_btn_prev <= bus.btn;
            r_led      <= w_led_nxt;
            r_busy     <= !((w_state_nxt == IDLE) || (w_state_nxt == WIN) || (w_state_nxt == LOSE));
            r_win      <= (w_state_nxt == WIN);
            r_lose     <= (w_state_nxt == LOSE);
        end
    end

    assign bus.led   = r_led;
    assign bus.level = r_level;
    assign bus.busy  = r_busy;
    assign bus.win   = r_win;
    assign bus.lose  = r_lose;
endmodule
`default_nettype wire

// File: doc/simon_seq_engine.md
Name: simon_seq_engine

Overview:
Parametrised Simon Says game engine that replaces the fixed 4-button, 3-bit-address FSM/memory pairing.
- Grows a random colour sequence one entry per round and stores it in an internal sequence RAM.
- Plays the sequence back on the LEDs with programmable on/gap times, then checks the player's presses with a per-press timeout.
- Sits between the clock divider (supplies `tick`), the random generator (supplies `rnd`) and the display/LED logic.

Parameters:
- N_BTN, 4, number of buttons/LEDs (2..8).
- MAX_LEN, 16, maximum sequence length; completing round MAX_LEN is a win.
- SHOW_TICKS, 4, ticks each LED is lit during playback (>=2).
- GAP_TICKS, 2, dark ticks between playback entries (>=1).
- TIMEOUT_TICKS, 32, ticks allowed per player press before loss.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- tick  in  1  single-cycle timing enable from the clock divider.
- start  in  1  pulse; starts or restarts a game.
- btn  in  N_BTN  synchronised, debounced buttons, level.
- rnd  in  IDX_W  random colour index; IDX_W = $clog2(N_BTN); values >= N_BTN are taken modulo N_BTN.
- led  out  N_BTN  one-hot playback/echo drive.
- level  out  LVL_W  current sequence length; LVL_W = $clog2(MAX_LEN+1).
- busy  out  1  high in every state except IDLE, WIN and LOSE.
- win  out  1  held high in WIN.
- lose  out  1  held high in LOSE.

Behaviour:
Reset and output rules:
- Reset (synchronous, active-high) takes effect at the next clk edge from any state, including mid-playback.
- Reset values: state=IDLE, led=0, level=0, busy=0, win=0, lose=0, all counters=0.
- RAM contents are not cleared; they are don't-care because `level` gates every read.
- All outputs are registered.

Edge detection:
- A press is registered on the cycle where btn!=0 and the previous-cycle btn==0.
- Holding a button generates no further presses.
- Releases are ignored.

State machine:
- IDLE: start=1 -> ADD on the next cycle.
- ADD: write rnd%N_BTN at address level; level<=level+1; idx<=0 -> SHOW_ON. Takes one cycle, no tick needed.
- SHOW_ON: led=onehot(mem[idx]); after SHOW_TICKS ticks -> SHOW_OFF.
- SHOW_OFF: led=0; after GAP_TICKS ticks:
  - if idx==level-1: idx<=0, timer<=0 -> INPUT;
  - else idx<=idx+1 -> SHOW_ON.
- INPUT: led mirrors btn while any button is held (echo). On a registered press:
  - btn must equal onehot(mem[idx]); any multi-hot or wrong value -> LOSE.
  - match with idx<level-1: idx++, timer<=0.
  - match with idx==level-1 and level==MAX_LEN -> WIN.
  - match with idx==level-1 otherwise -> ADD.
  - timer counts ticks since the last press; timer==TIMEOUT_TICKS -> LOSE.
- WIN/LOSE: led=0; outputs held. start=1 -> level<=0, then ADD.

Boundaries and simultaneous events:
- start while busy is ignored.
- A press and timeout on the same cycle: the press wins.
- A tick is not required for the ADD or compare transitions.
- `level` never exceeds MAX_LEN.

Optional Feature:
SIMON_SPEEDUP_EN
- Defined: playback on-time is SHOW_TICKS - min(level-1, SHOW_TICKS/2) ticks, so playback quickens as the sequence grows; the gap is unchanged.
- Undefined: on-time is fixed at SHOW_TICKS.
- Both builds have identical ports.

Decomposition:
- Package `simon_pkg` holds:
  - the state_t enum (IDLE, ADD, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE);
  - function onehot(idx, n);
  - IDX_W/LVL_W helper functions.
- Sub-module `simon_seq_ram`: MAX_LEN x IDX_W array, synchronous write, combinational read, ports w_en/w_addr/w_data/r_addr/r_data.
- The FSM, timers and edge detector stay in the top body.

Test Plan:
All scenarios use N_BTN=4, MAX_LEN=3, SHOW_TICKS=2, GAP_TICKS=1, TIMEOUT_TICKS=5, tick=1.
1. rst high 2 cycles mid-SHOW_ON -> next cycle state IDLE, led=0, level=0, busy=0.
2. start, rnd=2 -> level=1; led=4'b0100 for exactly 2 cycles, then 0 for 1 cycle; state INPUT.
3. rnd sequence 2,0,3 with correct presses each round -> level steps 1,2,3; after the final correct press win=1, busy=0.
4. Round 2 with stored 2,0; press 4'b0100 then 4'b0010 -> lose=1 on the cycle after the second press.
5. In INPUT, no press for 5 ticks -> lose=1. A press on the timeout cycle is accepted instead.
6. Multi-hot press 4'b0101 -> LOSE. Holding the correct button 10 cycles counts as one press. start in LOSE -> level=1 with the new rnd.
